vinsn_launcher: RTL and testbench

Sits between the vector instruction decoder and the vector functional units (ALU, load unit, store unit). Holds one decoded `issue_req_t` in a staging register and tracks register hazards with a per-vreg scoreboard. Routes the instruction to its unit by `vop` and releases scoreboard state on per-unit completion reports. Enforces RAW/WAW/WAR ordering and a global in-flight limit.

---
 rtl/rvv_pkg.sv | 52 +++++
 rtl/vreg_scoreboard.sv | 90 +++++++++
 rtl/vinsn_launcher.sv | 110 +++++++++++
 tb/tb_vinsn_launcher.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Shared vector-issue types: request bundle, IDs, unit routing and launcher states.
// The RVV_LAUNCH_PERF_EN macro (used by vinsn_launcher) adds performance counters.
package rvv_pkg;

    typedef logic [2:0] insn_id_t;
    typedef logic [4:0] vreg_t;

    localparam int unsigned NrIds   = 2 ** $bits(insn_id_t);
    localparam int unsigned NrUnits = 3;

    // Operand slot indices into vs/use_vs
    localparam int unsigned VS1 = 0;
    localparam int unsigned VS2 = 1;
    localparam int unsigned VD  = 2;

    typedef enum logic [3:0] {
        VADD, VSUB, VAND, VOR, VXOR, VMUL, VLE, VSE
    } vop_e;

    typedef enum logic [1:0] {
        UnitAlu, UnitLdu, UnitStu
    } unit_e;

    typedef enum logic [1:0] {
        EMPTY, HAZARD, DISPATCH
    } launch_state_e;

    typedef struct packed {
        vop_e       vop;
        insn_id_t   id;
        vreg_t      vd;
        vreg_t      vs2;
        vreg_t      vs1;
        logic [2:0] use_vs;
        logic [7:0] vl;
    } issue_req_t;

    typedef struct packed {
        logic            valid;
        vreg_t [2:0]     vs;
        logic [2:0]      use_vs;
    } id_entry_t;

    function automatic unit_e vop2unit(vop_e op);
        case (op)
            VLE:     return UnitLdu;
            VSE:     return UnitStu;
            default: return UnitAlu;
        endcase
    endfunction

endpackage

// File: rtl/vreg_scoreboard.sv
// Per-vreg write-pending / reader-count scoreboard with an insn-ID table.
// Dispatch and up to NrUnits completions per cycle are applied as summed deltas.
module vreg_scoreboard
    import rvv_pkg::*;
#(
    parameter int unsigned MaxInflight = 4,
    parameter int unsigned NrVregs     = 32,
    parameter int unsigned InflW       = $clog2(MaxInflight + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      disp_i,
    input  issue_req_t                disp_req_i,
    input  logic [NrUnits-1:0]        done_valid_i,
    input  insn_id_t [NrUnits-1:0]    done_id_i,
    input  issue_req_t                query_i,
    output logic                      hazard_o,
    output logic [InflW-1:0]          inflight_o
);

    // Each in-flight insn may read the same vreg twice (vs1 == vs2)
    localparam int unsigned CntW = $clog2(2 * MaxInflight + 1);

    logic [NrVregs-1:0]            wr_q, wr_d;
    logic [NrVregs-1:0][CntW-1:0]  cnt_q, cnt_d;
    id_entry_t [NrIds-1:0]         ent_q, ent_d;
    logic [InflW-1:0]              inflight_q, inflight_d;
    logic [1:0]                    ndone;
    id_entry_t                     de;

    always_comb begin
        wr_d  = wr_q;
        cnt_d = cnt_q;
        ent_d = ent_q;
        ndone = '0;
        de    = '0;
        for (int k = 0; k < NrUnits; k++) begin
            de = ent_q[done_id_i[k]];
            if (done_valid_i[k] && de.valid) begin
                ndone = ndone + 2'd1;
                ent_d[done_id_i[k]].valid = 1'b0;
                if (de.use_vs[VD]) wr_d[de.vs[VD]] = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    if (de.use_vs[s])
                        cnt_d[de.vs[s]] = cnt_d[de.vs[s]] - CntW'(1);
                end
            end
        end
        if (disp_i) begin
            ent_d[disp_req_i.id].valid  = 1'b1;
            ent_d[disp_req_i.id].vs     = {disp_req_i.vd, disp_req_i.vs2, disp_req_i.vs1};
            ent_d[disp_req_i.id].use_vs = disp_req_i.use_vs;
            if (disp_req_i.use_vs[VD]) wr_d[disp_req_i.vd] = 1'b1;
            if (disp_req_i.use_vs[VS1])
                cnt_d[disp_req_i.vs1] = cnt_d[disp_req_i.vs1] + CntW'(1);
            if (disp_req_i.use_vs[VS2])
                cnt_d[disp_req_i.vs2] = cnt_d[disp_req_i.vs2] + CntW'(1);
        end
        inflight_d = InflW'(32'(inflight_q) + 32'(disp_i) - 32'(ndone));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q       <= '0;
            cnt_q      <= '0;
            ent_q      <= '0;
            inflight_q <= '0;
        end else begin
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            ent_q      <= ent_d;
            inflight_q <= inflight_d;
        end
    end

    assign hazard_o = (query_i.use_vs[VS1] && wr_q[query_i.vs1])
                   || (query_i.use_vs[VS2] && wr_q[query_i.vs2])
                   || (query_i.use_vs[VD]  && wr_q[query_i.vd])
                   || (query_i.use_vs[VD]  && cnt_q[query_i.vd] != '0)
                   || (inflight_q == InflW'(MaxInflight));

    assign inflight_o = inflight_q;

    for (genvar k = 0; k < NrUnits; k++) begin : g_done_chk
        a_done_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
            done_valid_i[k] |-> ent_q[done_id_i[k]].valid)
            else $error("done reported for idle insn id on unit %0d", k);
    end

endmodule

// File: rtl/vinsn_launcher.sv
// Vector instruction launcher: one staging slot, hazard wait, per-unit dispatch.
// Define RVV_LAUNCH_PERF_EN to add perf_dispatch_o / perf_stall_o counters.
module vinsn_launcher
    import rvv_pkg::*;
#(
    parameter int unsigned MaxInflight = 4,
    parameter int unsigned NrVregs     = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  issue_req_t                          issue_req_i,
    output logic [NrUnits-1:0]                  unit_valid_o,
    input  logic [NrUnits-1:0]                  unit_ready_i,
    output issue_req_t                          unit_req_o,
    input  logic [NrUnits-1:0]                  done_valid_i,
    input  insn_id_t [NrUnits-1:0]              done_id_i,
    output logic [$clog2(MaxInflight+1)-1:0]    inflight_o,
`ifdef RVV_LAUNCH_PERF_EN
    output logic [31:0]                         perf_dispatch_o,
    output logic [31:0]                         perf_stall_o,
`endif
    output logic                                idle_o
);

    launch_state_e state_q, state_d;
    issue_req_t    req_q, req_d;
    unit_e         sel;
    logic          sel_ready;
    logic          hazard;
    logic          accept;
    logic          disp;

    assign sel       = vop2unit(req_q.vop);
    assign sel_ready = unit_ready_i[sel];
    assign accept    = req_valid_i && req_ready_o;
    assign disp      = (state_q == DISPATCH) && sel_ready;
    assign req_d     = accept ? issue_req_i : req_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:    if (accept) state_d = HAZARD;
            HAZARD:   if (!hazard) state_d = DISPATCH;
            DISPATCH: if (sel_ready) state_d = accept ? HAZARD : EMPTY;
            default:  state_d = EMPTY;
        endcase
    end

    always_comb begin
        unit_valid_o = '0;
        req_ready_o  = 1'b0;
        unique case (state_q)
            EMPTY: req_ready_o = 1'b1;
            DISPATCH: begin
                unit_valid_o[sel] = 1'b1;
                req_ready_o       = sel_ready;
            end
            default: ;
        endcase
    end

    vreg_scoreboard #(
        .MaxInflight (MaxInflight),
        .NrVregs     (NrVregs)
    ) i_sb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .disp_i       (disp),
        .disp_req_i   (req_q),
        .done_valid_i (done_valid_i),
        .done_id_i    (done_id_i),
        .query_i      (req_q),
        .hazard_o     (hazard),
        .inflight_o   (inflight_o)
    );

    assign unit_req_o = req_q;
    assign idle_o     = (state_q == EMPTY) && (inflight_o == '0);

`ifdef RVV_LAUNCH_PERF_EN
    logic [31:0] perf_disp_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_disp_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (disp) perf_disp_q <= perf_disp_q + 32'd1;
            if ((state_q == HAZARD && hazard) || (state_q == DISPATCH && !sel_ready))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_dispatch_o = perf_disp_q;
    assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_vinsn_launcher.sv
// Directed bench for vinsn_launcher: hazards, unit routing, in-flight limit,
// backpressure and mid-operation reset.
module tb_vinsn_launcher;
    import rvv_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    issue_req_t           req;
    logic [2:0]           unit_valid;
    logic [2:0]           unit_ready;
    issue_req_t           unit_req;
    logic [2:0]           done_valid;
    insn_id_t [2:0]       done_id;
    logic [2:0]           inflight;
    logic                 idle;
`ifdef RVV_LAUNCH_PERF_EN
    logic [31:0]          perf_dispatch;
    logic [31:0]          perf_stall;
    logic [31:0]          perf0;
`endif

    int checks   = 0;
    int failures = 0;
    issue_req_t held;

    localparam logic [2:0] U_ALL = 3'b111;
    localparam logic [2:0] U_VD  = 3'b100;
    localparam logic [2:0] U_S1  = 3'b001;

    vinsn_launcher #(.MaxInflight(4), .NrVregs(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .issue_req_i     (req),
        .unit_valid_o    (unit_valid),
        .unit_ready_i    (unit_ready),
        .unit_req_o      (unit_req),
        .done_valid_i    (done_valid),
        .done_id_i       (done_id),
        .inflight_o      (inflight),
`ifdef RVV_LAUNCH_PERF_EN
        .perf_dispatch_o (perf_dispatch),
        .perf_stall_o    (perf_stall),
`endif
        .idle_o          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic issue_req_t mk(vop_e op, int id, int vd, int vs1, int vs2,
                                      logic [2:0] use_vs);
        issue_req_t r;
        r        = '0;
        r.vop    = op;
        r.id     = insn_id_t'(id);
        r.vd     = vreg_t'(vd);
        r.vs1    = vreg_t'(vs1);
        r.vs2    = vreg_t'(vs2);
        r.use_vs = use_vs;
        r.vl     = 8'd4;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic done1(input int unit, input int id);
        done_valid       = '0;
        done_valid[unit] = 1'b1;
        done_id[unit]    = insn_id_t'(id);
        step();
        done_valid       = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req        = '0;
        unit_ready = 3'b111;
        done_valid = '0;
        done_id    = '0;
        step();
        step();
        chk("rst_idle",     64'(idle), 64'd1);
        chk("rst_ready",    64'(req_ready), 64'd1);
        chk("rst_valid",    64'(unit_valid), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        rst_n = 1'b1;
        step();

        // RAW: vadd v1,v2,v3 then vadd v4,v1,v5
        req_valid = 1'b1;
        req = mk(VADD, 0, 1, 2, 3, U_ALL);
        step();
        req = mk(VADD, 1, 4, 1, 5, U_ALL);
        chk("t1_haz_ready", 64'(req_ready), 64'd0);
        chk("t1_haz_valid", 64'(unit_valid), 64'd0);
        step();
        chk("t1_lat2",   64'(unit_valid), 64'b001);
        chk("t1_id0",    64'(unit_req.id), 64'd0);
        chk("t1_rdy_dp", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk("t1_infl1",  64'(inflight), 64'd1);
        step();
        chk("t1_raw_a",  64'(unit_valid), 64'd0);
        step();
        chk("t1_raw_b",  64'(unit_valid), 64'd0);
        done1(0, 0);
        chk("t1_no_bypass", 64'(unit_valid), 64'd0);
        chk("t1_infl0",  64'(inflight), 64'd0);
        step();
        chk("t1_release", 64'(unit_valid), 64'b001);
        chk("t1_id1",    64'(unit_req.id), 64'd1);
        step();
        chk("t1_infl_b", 64'(inflight), 64'd1);
        done1(0, 1);
        chk("t1_idle",   64'(idle), 64'd1);

        // WAR: vse v8 then vle v8
        req_valid = 1'b1;
        req = mk(VSE, 0, 0, 8, 0, U_S1);
        step();
        req = mk(VLE, 1, 8, 0, 0, U_VD);
        step();
        chk("t2_stu", 64'(unit_valid), 64'b100);
        step();
        req_valid = 1'b0;
        step();
        chk("t2_war_hold", 64'(unit_valid), 64'd0);
        done1(2, 0);
        step();
        chk("t2_ldu", 64'(unit_valid), 64'b010);
        step();
        chk("t2_infl", 64'(inflight), 64'd1);
        done1(1, 1);
        chk("t2_idle", 64'(idle), 64'd1);

        // WAW: vle v2 twice, independent vadd waits only at head of line
        req_valid = 1'b1;
        req = mk(VLE, 0, 2, 0, 0, U_VD);
        step();
        req = mk(VLE, 1, 2, 0, 0, U_VD);
        step();
        step();
        req = mk(VADD, 2, 9, 10, 11, U_ALL);
        chk("t3_hol_ready", 64'(req_ready), 64'd0);
        step();
        chk("t3_waw_hold", 64'(unit_valid), 64'd0);
        done1(1, 0);
        chk("t3_hol_ready2", 64'(req_ready), 64'd0);
        step();
        chk("t3_ldu", 64'(unit_valid), 64'b010);
        chk("t3_id1", 64'(unit_req.id), 64'd1);
        chk("t3_rdy", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk("t3_reload", 64'(unit_valid), 64'd0);
        step();
        chk("t3_indep", 64'(unit_valid), 64'b001);
        chk("t3_id2", 64'(unit_req.id), 64'd2);
        step();
        chk("t3_infl2", 64'(inflight), 64'd2);
        done_valid = 3'b011;
        done_id[0] = 3'd2;
        done_id[1] = 3'd1;
        step();
        done_valid = '0;
        chk("t3_dual_done", 64'(inflight), 64'd0);

        // In-flight limit with vs1 == vs2 double reader counts
        req_valid = 1'b1;
        req = mk(VADD, 0, 10, 20, 20, U_ALL);
        step();
        for (int i = 1; i < 5; i++) begin
            req = mk(VADD, i, 10 + i, 20, 20, U_ALL);
            step();
            step();
        end
        req_valid = 1'b0;
        chk("t4_full", 64'(inflight), 64'd4);
        step();
        chk("t4_limit_a", 64'(unit_valid), 64'd0);
        step();
        chk("t4_limit_b", 64'(unit_valid), 64'd0);
        chk("t4_full_b", 64'(inflight), 64'd4);
        done1(0, 0);
        chk("t4_infl3", 64'(inflight), 64'd3);
        chk("t4_wait", 64'(unit_valid), 64'd0);
        step();
        chk("t4_go", 64'(unit_valid), 64'b001);
        chk("t4_id4", 64'(unit_req.id), 64'd4);
        step();
        chk("t4_4to4", 64'(inflight), 64'd4);
        done_valid = 3'b111;
        done_id[0] = 3'd1;
        done_id[1] = 3'd2;
        done_id[2] = 3'd3;
        step();
        done_valid = '0;
        chk("t4_tri_done", 64'(inflight), 64'd1);
        done1(0, 4);
        chk("t4_drain", 64'(inflight), 64'd0);
        req_valid = 1'b1;
        req = mk(VADD, 5, 20, 1, 1, U_VD);
        step();
        req_valid = 1'b0;
        step();
        chk("t4_cnt_clear", 64'(unit_valid), 64'b001);
        step();
        done1(0, 5);
        chk("t4_idle", 64'(idle), 64'd1);

        // ALU backpressure for 5 cycles
        unit_ready = 3'b110;
        held = mk(VADD, 6, 3, 4, 5, U_ALL);
        req_valid = 1'b1;
        req = held;
        step();
        req_valid = 1'b0;
        req = mk(VSUB, 7, 30, 31, 29, U_ALL);
        step();
        chk("t5_valid", 64'(unit_valid), 64'b001);
`ifdef RVV_LAUNCH_PERF_EN
        perf0 = perf_stall;
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_valid", 64'(unit_valid), 64'b001);
            chk("t5_hold_req", 64'(unit_req), 64'(held));
            chk("t5_hold_rdy", 64'(req_ready), 64'd0);
        end
`ifdef RVV_LAUNCH_PERF_EN
        chk("t5_perf_stall", 64'(perf_stall - perf0), 64'd5);
`endif
        unit_ready = 3'b111;
        step();
        chk("t5_disp", 64'(inflight), 64'd1);
        chk("t5_drop", 64'(unit_valid), 64'd0);

        // Reset with two in flight and one staged
        req_valid = 1'b1;
        req = mk(VADD, 7, 6, 7, 7, U_ALL);
        step();
        step();
        req = mk(VADD, 0, 3, 12, 13, U_ALL);
        step();
        req_valid = 1'b0;
        chk("t6_infl2", 64'(inflight), 64'd2);
        step();
        chk("t6_staged", 64'(unit_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_infl", 64'(inflight), 64'd0);
        chk("t6_rst_idle", 64'(idle), 64'd1);
        step();
        chk("t6_rst_valid", 64'(unit_valid), 64'd0);
        rst_n = 1'b1;
        step();
        req_valid = 1'b1;
        req = mk(VADD, 1, 3, 6, 6, U_ALL);
        step();
        req_valid = 1'b0;
        step();
        chk("t6_sb_clear", 64'(unit_valid), 64'b001);
        step();
        chk("t6_infl1", 64'(inflight), 64'd1);
        done1(0, 1);
        chk("t6_idle", 64'(idle), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
